mem_result_writer: RTL and testbench
====================================

// Module: mem_result_writer
// PURPOSE
//  Write-side counterpart of the matrix-A row reader. Collects per-lane chunks of no_of_units
//  elements from the row_by_vector modules and packs them into one wide row, laid out exactly
//  as the reader slices it. When the row is complete, issues one write of the packed row.
//  Sits between the row_by_vector result lanes and the result memory.
// PARAMETERS
//  no_of_elements_on_col_nos   20  elements per lane per row (E)
//  no_of_row_by_vector_modules 4   number of lanes (N)
//  element_width               32  bits per element (W)
//  no_of_units                 2*N elements per chunk (U)
//  overflow_allowed            E%U valid elements in a lane's final partial chunk
// PORTS
//  clk                 in   1          clock, rising edge
//  rst_n               in   1          synchronous reset, active low
//  start               in   1          begin a row; sampled in IDLE only
//  write_address       in   32         row address; latched on accepted start
//  no_of_multiples     in   32*N       beats per lane; lane l (1..N) at [l*32-1 -: 32]; latched on start
//  in_valid            in   1          in_data holds a beat
//  in_ready            out  1          high only in COLLECT
//  in_data             in   N*U*W      lane l chunk at [l*U*W-1 -: U*W], first element at MSB
//  mem_write_en        out  1          one-cycle write strobe
//  mem_write_address   out  32         latched write_address
//  mem_write_data      out  N*E*W      packed row; lane l at [l*E*W-1 -: E*W]
//  busy                out  1          high outside IDLE
//  done                out  1          one-cycle pulse at end of row
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE; beat counter=1; row buffer=0; all outputs 0.
//    Reset during any state discards the partial row; no write is issued.
//  - FSM: IDLE -> COLLECT on start when max(no_of_multiples) > 0; IDLE -> DONE on start when
//    all counts are 0 (no write). COLLECT -> WRITE on the accepted beat b == max count.
//    WRITE -> DONE after 1 cycle. DONE -> IDLE after 1 cycle.
//  - start: latches address and counts, clears row buffer, sets b=1. Ignored when busy.
//  - Handshake: a beat is accepted when in_valid & in_ready. in_valid outside COLLECT is ignored.
//    Each accepted beat increments b. in_data need not be held after acceptance.
//  - Placement of lane l, beat b (top bit index T = (l*E-(b-1)*U)*W-1):
//    b > count[l]                -> lane ignored for this beat
//    (b-1)*U >= E                -> ignored (count too large for E)
//    E < b*U (final partial)     -> only top overflow_allowed*W bits of the chunk are written to
//                                   row[T -: overflow_allowed*W]; zero pad bits are discarded
//    otherwise                   -> row[T -: U*W] = chunk
//  - Lanes with different counts progress together. A lane whose count is exhausted keeps its
//    bits; bits never written stay 0.
//  - Latency: start at cycle t -> in_ready at t+1. Last beat accepted at T -> mem_write_en=1 at
//    T+1 with address and data stable; done=1 at T+2; IDLE (busy=0) at T+3.
//  - mem_write_data holds the row buffer in every state. It is meaningful only while
//    mem_write_en=1.
//  - A start asserted in the same cycle as done is ignored. The next row needs a start in IDLE.
// TESTING  (E=20, U=8, N=4, W=32; element e of lane l = {l[15:0], e[15:0]}, e=0..19, MSB-first)
//  1 counts=3,3,3,3, addr=5, beats with in_valid held high -> in_ready for exactly 3 cycles.
//    Then one mem_write_en with addr 5. Lane l occupies bits [l*640-1 -: 640] with e=0..19 in
//    MSB->LSB order. The pad words of beat 3 are nonzero garbage and do not appear in the row.
//  2 counts=3,2,1,0 -> 3 beats. Lane4 has 20 elements, lane3 has 16 elements with the low 4 = 0,
//    lane2 has 8 elements with the low 12 = 0, lane1 is all zero.
//  3 in_valid toggled 1,0,0,1,0,1 -> only 3 beats accepted. The row matches test 1 and the
//    write occurs 1 cycle after the 3rd acceptance.
//  4 counts all 0 -> no mem_write_en; done 1 cycle after start; busy low the cycle after.
//  5 rst_n=0 after beat 2 -> next cycle all outputs 0 and no write. A new start plus 3 beats
//    yields a row with no residue of the aborted row.
//  6 start asserted during COLLECT with a different addr -> ignored; write uses the original addr.

Source files
------------

// File: rtl/mem_result_writer.sv
// Collects per-lane result chunks from the row_by_vector lanes and packs them into one wide row.
// The row is laid out the same way the matrix-A row reader slices it, then written to memory in one cycle.
module mem_result_writer #(
  parameter int no_of_elements_on_col_nos   = 20,
  parameter int no_of_row_by_vector_modules = 4,
  parameter int element_width               = 32,
  parameter int no_of_units                 = 2 * no_of_row_by_vector_modules,
  parameter int overflow_allowed            = no_of_elements_on_col_nos % no_of_units
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [31:0]                          write_address,
  input  logic [32*no_of_row_by_vector_modules-1:0] no_of_multiples,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [no_of_row_by_vector_modules*no_of_units*element_width-1:0] in_data,
  output logic                                 mem_write_en,
  output logic [31:0]                          mem_write_address,
  output logic [no_of_row_by_vector_modules*no_of_elements_on_col_nos*element_width-1:0] mem_write_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int E         = no_of_elements_on_col_nos;
  localparam int N         = no_of_row_by_vector_modules;
  localparam int W         = element_width;
  localparam int U         = no_of_units;
  localparam int ROW_W     = N * E * W;
  localparam int CHUNK_W   = N * U * W;
  localparam int MAX_BEATS = (E + U - 1) / U;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [31:0]      beat_cnt;
  logic [31:0]      last_beat;
  logic [32*N-1:0]  counts;
  logic [31:0]      addr_r;
  logic [ROW_W-1:0] row_buf;
  logic             vld_p0;

  function automatic logic [31:0] max_count(input logic [32*N-1:0] c);
    logic [31:0] m;
    m = '0;
    for (int l = 1; l <= N; l++) begin
      if (c[l*32-1 -: 32] > m) m = c[l*32-1 -: 32];
    end
    return m;
  endfunction

  // Beats past what E can hold are dropped; the final partial chunk contributes only
  // its leading overflow_allowed elements, so the zero pad never reaches the row.
  function automatic logic [ROW_W-1:0] place_beat(input logic [ROW_W-1:0]   row,
                                                  input logic [CHUNK_W-1:0] chunk,
                                                  input logic [31:0]        beat,
                                                  input logic [32*N-1:0]    cnt);
    logic [ROW_W-1:0] r;
    int               base;
    int               nwr;
    r = row;
    if (beat != 32'd0 && beat <= 32'(MAX_BEATS)) begin
      base = (int'(beat) - 1) * U;
      nwr  = (int'(beat) * U > E) ? overflow_allowed : U;
      for (int l = 1; l <= N; l++) begin
        if (beat <= cnt[l*32-1 -: 32]) begin
          for (int j = 0; j < U; j++) begin
            if (j < nwr) r[(l*E - base - j)*W-1 -: W] = chunk[(l*U - j)*W-1 -: W];
          end
        end
      end
    end
    return r;
  endfunction

  assign vld_p0 = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= 32'd1;
      last_beat <= '0;
      counts    <= '0;
      addr_r    <= '0;
      row_buf   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_r    <= write_address;
            counts    <= no_of_multiples;
            last_beat <= max_count(no_of_multiples);
            row_buf   <= '0;
            beat_cnt  <= 32'd1;
            state     <= (max_count(no_of_multiples) != 32'd0) ? S_COLLECT : S_DONE;
          end
        end
        S_COLLECT: begin
          if (vld_p0) begin
            row_buf  <= place_beat(row_buf, in_data, beat_cnt, counts);
            beat_cnt <= beat_cnt + 32'd1;
            if (beat_cnt == last_beat) state <= S_WRITE;
          end
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready          = (state == S_COLLECT);
  assign mem_write_en      = (state == S_WRITE);
  assign done              = (state == S_DONE);
  assign busy              = (state != S_IDLE);
  assign mem_write_address = addr_r;
  assign mem_write_data    = row_buf;

endmodule

// File: tb/tb_mem_result_writer.sv
// Directed bench for mem_result_writer: a timeline model predicts handshake, strobes and the packed row;
// literal checks pin selected row words, addresses and write counts.
module tb_mem_result_writer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   write_address;
  logic [127:0]  no_of_multiples;
  logic          in_valid;
  logic          in_ready;
  logic [1023:0] in_data;
  logic          mem_write_en;
  logic [31:0]   mem_write_address;
  logic [2559:0] mem_write_data;
  logic          busy;
  logic          done;

  mem_result_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write_address(write_address),
    .no_of_multiples(no_of_multiples), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_write_en(mem_write_en), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [2559:0] act, input logic [2559:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int w = 79; w >= 0; w--) begin
        if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
          $display("FAIL %s first bad word %0d actual=%h required=%h", name, w,
                   act[w*32 +: 32], exp[w*32 +: 32]);
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] elem(input int l, input int e);
    return {16'(l), 16'(e)};
  endfunction

  // Beat b carries elements (b-1)*8.. for every lane; slots past element 19 hold garbage.
  function automatic logic [1023:0] chunk(input int b);
    logic [1023:0] c;
    int e;
    for (int l = 1; l <= 4; l++)
      for (int j = 0; j < 8; j++) begin
        e = (b - 1) * 8 + j;
        c[(l*8 - j)*32-1 -: 32] = (e < 20) ? elem(l, e) : (32'hBAD0_0000 | 32'(l << 8) | 32'(j));
      end
    return c;
  endfunction

  // Timeline model: intervals are numbered by the rising edge that opens them.
  int  m_p = 0;
  bit  m_busy = 0, m_coll = 0, m_zero = 0;
  int  m_got, m_max;
  int  m_cnt [1:4];
  int  m_we_edge = -1, m_done_edge = -1, m_idle_edge = -1;
  logic [31:0] m_addr = '0;

  // A lane ends up holding its first min(8*count, 20) elements; everything else is zero.
  function automatic logic [2559:0] exp_row();
    logic [2559:0] r;
    r = '0;
    for (int l = 1; l <= 4; l++)
      for (int e = 0; e < 20; e++)
        if (e < m_cnt[l] * 8) r[(l*20 - e)*32-1 -: 32] = elem(l, e);
    return r;
  endfunction

  always @(posedge clk) begin
    m_p++;
    if (!rst_n) begin
      m_busy = 0; m_coll = 0; m_zero = 1; m_addr = '0;
      m_we_edge = -1; m_done_edge = -1; m_idle_edge = -1;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_zero = 0; m_addr = write_address; m_got = 0; m_max = 0;
        for (int l = 1; l <= 4; l++) begin
          m_cnt[l] = int'(no_of_multiples[l*32-1 -: 32]);
          if (m_cnt[l] > m_max) m_max = m_cnt[l];
        end
        if (m_max == 0) begin
          m_done_edge = m_p; m_idle_edge = m_p + 1;
        end else m_coll = 1;
      end
    end else if (m_coll) begin
      if (in_valid) begin
        m_got++;
        if (m_got == m_max) begin
          m_coll = 0; m_we_edge = m_p; m_done_edge = m_p + 1; m_idle_edge = m_p + 2;
        end
      end
    end else if (m_p == m_idle_edge) m_busy = 0;
  end

  int            wr_cnt = 0;
  logic [31:0]   cap_addr;
  logic [2559:0] cap_data;

  always @(negedge clk) begin
    if (m_p >= 1) begin
      chk("in_ready", 64'(in_ready), 64'(m_coll));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_p == m_done_edge));
      chk("mem_write_en", 64'(mem_write_en), 64'(m_p == m_we_edge));
      if (m_zero) begin
        chk("addr_after_reset", 64'(mem_write_address), 64'h0);
        chk("data_after_reset", 64'(|mem_write_data), 64'h0);
      end
      if (m_p == m_we_edge) begin
        chk("write_addr", 64'(mem_write_address), 64'(m_addr));
        chk_row("write_data", mem_write_data, exp_row());
      end
      if (mem_write_en) begin
        wr_cnt++; cap_addr = mem_write_address; cap_data = mem_write_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [31:0] a, input int c1, input int c2, input int c3, input int c4);
    start = 1; write_address = a;
    no_of_multiples = {32'(c4), 32'(c3), 32'(c2), 32'(c1)};
    tick();
    start = 0;
  endtask

  task automatic beats(input string name, input int target, input int first, input logic [15:0] pat,
                       output int rdy_cyc);
    int acc;
    acc = 0; rdy_cyc = 0;
    for (int i = 0; i < 16 && acc < target; i++) begin
      in_valid = pat[i];
      in_data  = chunk(first + acc);
      if (in_ready) rdy_cyc++;
      if (pat[i] && in_ready) acc++;
      tick();
    end
    in_valid = 0;
    chk(name, 64'(acc), 64'(target));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 10 && busy; i++) tick();
    chk(name, 64'(busy), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rc, w0;
    rst_n = 0; start = 0; write_address = '0; no_of_multiples = '0;
    in_valid = 0; in_data = '0;
    tick(); tick();
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_data", 64'(|mem_write_data), 64'h0);
    rst_n = 1; tick();

    // 1: full row, valid held high
    w0 = wr_cnt;
    do_start(32'd5, 3, 3, 3, 3);
    beats("t1_accepted", 3, 1, 16'hFFFF, rc);
    chk("t1_ready_cycles", 64'(rc), 64'd3);
    chk("t1_we_next", 64'(mem_write_en), 64'h1);
    wait_idle("t1_idle");
    chk("t1_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t1_addr", 64'(cap_addr), 64'd5);
    chk("t1_l4_e0", 64'(cap_data[2559 -: 32]), 64'h0004_0000);
    chk("t1_l1_e0", 64'(cap_data[639 -: 32]), 64'h0001_0000);
    chk("t1_l1_e19", 64'(cap_data[31:0]), 64'h0001_0013);

    // 2: uneven counts
    w0 = wr_cnt;
    do_start(32'd6, 0, 1, 2, 3);
    beats("t2_accepted", 3, 1, 16'hFFFF, rc);
    wait_idle("t2_idle");
    chk("t2_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t2_l3_e15", 64'(cap_data[1439 -: 32]), 64'h0003_000F);
    chk("t2_l3_e16", 64'(cap_data[1407 -: 32]), 64'h0);
    chk("t2_l2_e7", 64'(cap_data[1055 -: 32]), 64'h0002_0007);
    chk("t2_l2_e8", 64'(cap_data[1023 -: 32]), 64'h0);
    chk("t2_l1_zero", 64'(|cap_data[639:0]), 64'h0);

    // 3: gapped valid
    w0 = wr_cnt;
    do_start(32'd5, 3, 3, 3, 3);
    beats("t3_accepted", 3, 1, 16'h0029, rc);
    chk("t3_ready_cycles", 64'(rc), 64'd6);
    chk("t3_we_next", 64'(mem_write_en), 64'h1);
    wait_idle("t3_idle");
    chk("t3_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t3_l4_e19", 64'(cap_data[1951 -: 32]), 64'h0004_0013);

    // 4: all counts zero, start held into the done cycle
    w0 = wr_cnt;
    start = 1; write_address = 32'd8; no_of_multiples = '0;
    tick();
    chk("t4_done", 64'(done), 64'h1);
    tick();
    start = 0;
    chk("t4_idle", 64'(busy), 64'h0);
    tick();
    chk("t4_writes", 64'(wr_cnt - w0), 64'd0);

    // 5: reset mid-row
    w0 = wr_cnt;
    do_start(32'd7, 3, 3, 3, 3);
    beats("t5_accepted", 2, 1, 16'hFFFF, rc);
    rst_n = 0; tick();
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_we", 64'(mem_write_en), 64'h0);
    chk("t5_addr", 64'(mem_write_address), 64'h0);
    chk("t5_data", 64'(|mem_write_data), 64'h0);
    rst_n = 1; tick();
    chk("t5_no_write", 64'(wr_cnt - w0), 64'd0);
    do_start(32'd9, 0, 3, 3, 3);
    beats("t5b_accepted", 3, 1, 16'hFFFF, rc);
    wait_idle("t5_idle");
    chk("t5_writes", 64'(wr_cnt - w0), 64'd1);
    chk("t5_l1_zero", 64'(|cap_data[639:0]), 64'h0);
    chk("t5_l2_e0", 64'(cap_data[1279 -: 32]), 64'h0002_0000);

    // 6: start during collect is ignored
    do_start(32'd11, 3, 3, 3, 3);
    beats("t6a_accepted", 1, 1, 16'hFFFF, rc);
    start = 1; write_address = 32'd99; tick(); start = 0;
    beats("t6b_accepted", 2, 2, 16'hFFFF, rc);
    wait_idle("t6_idle");
    chk("t6_addr", 64'(cap_addr), 64'd11);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
